// File: rtl/parking_lot_ctrl.sv
// Multi-lane parking-lot controller: per-lane gate FSMs, slot reservation and occupancy count.
// Optional per-lane OPEN timeout enabled with the LOT_TIMEOUT_EN macro.
module parking_lot_ctrl #(
    parameter int unsigned CAPACITY = 10,
    parameter int unsigned NIN      = 2,
    parameter int unsigned NOUT     = 2,
    parameter int unsigned TIMEOUT  = 15,
    localparam int unsigned CW      = $clog2(CAPACITY + 1)
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [NIN-1:0]      in_a,
    input  logic [NIN-1:0]      in_b,
    input  logic [NOUT-1:0]     out_a,
    input  logic [NOUT-1:0]     out_b,
    output logic [NIN-1:0]      in_open,
    output logic [NOUT-1:0]     out_open,
    output logic [NIN-1:0]      in_wait,
    output logic [CW-1:0]       occupancy,
    output logic                full,
    output logic                empty,
    output logic                in_pulse,
    output logic                out_pulse,
    output logic [NIN+NOUT-1:0] timeout_err
);

    localparam int NumIn = int'(NIN);
    localparam int NumL  = int'(NIN + NOUT);

    typedef enum logic [1:0] {StIdle, StOpen, StPass, StCommit} lane_state_e;

    lane_state_e       st_q [NumL];
    lane_state_e       st_d [NumL];
    logic [NumL-1:0]   s1, s2, grant, tmo_hit, open_vec, commit_vec;
    logic [CW-1:0]     occ_q, occ_d;
    int                occ_next;

    // Lanes 0..NIN-1 are entries, NIN..NIN+NOUT-1 are exits.
    assign s1 = {out_a, in_a};
    assign s2 = {out_b, in_b};

    always_comb begin : grant_logic
        int pend_in, pend_out, free, avail;
        pend_in  = 0;
        pend_out = 0;
        for (int l = 0; l < NumIn; l++) begin
            if (st_q[l] != StIdle) pend_in++;
        end
        for (int l = NumIn; l < NumL; l++) begin
            if (st_q[l] != StIdle) pend_out++;
        end
        free    = int'(CAPACITY) - int'(occ_q) - pend_in;
        avail   = int'(occ_q) - pend_out;
        grant   = '0;
        in_wait = '0;
        for (int l = 0; l < NumIn; l++) begin
            if (st_q[l] == StIdle && s1[l]) begin
                if (free > 0) begin
                    grant[l] = 1'b1;
                    free--;
                end else begin
                    in_wait[l] = 1'b1;
                end
            end
        end
        for (int l = NumIn; l < NumL; l++) begin
            if (st_q[l] == StIdle && s1[l] && avail > 0) begin
                grant[l] = 1'b1;
                avail--;
            end
        end
    end

    always_comb begin : lane_fsm
        for (int l = 0; l < NumL; l++) begin
            st_d[l]       = st_q[l];
            open_vec[l]   = (st_q[l] == StOpen) || (st_q[l] == StPass);
            commit_vec[l] = (st_q[l] == StCommit);
            unique case (st_q[l])
                StIdle:   if (grant[l]) st_d[l] = StOpen;
                StOpen: begin
                    if (s2[l])                     st_d[l] = StPass;
                    else if (!s1[l] || tmo_hit[l]) st_d[l] = StIdle;
                end
                StPass:   if (!s1[l] && !s2[l]) st_d[l] = StCommit;
                StCommit: st_d[l] = StIdle;
            endcase
        end
    end

    always_comb begin : count_update
        int n_in, n_out;
        n_in  = 0;
        n_out = 0;
        for (int l = 0; l < NumIn; l++)    n_in  += int'(commit_vec[l]);
        for (int l = NumIn; l < NumL; l++) n_out += int'(commit_vec[l]);
        occ_next = int'(occ_q) + n_in - n_out;
        occ_d    = occ_next[CW-1:0];
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int l = 0; l < NumL; l++) st_q[l] <= StIdle;
            occ_q <= '0;
        end else begin
            for (int l = 0; l < NumL; l++) st_q[l] <= st_d[l];
            occ_q <= occ_d;
            // Reservations guarantee the count never leaves 0..CAPACITY.
            assert (occ_next >= 0 && occ_next <= int'(CAPACITY) && TIMEOUT > 0);
        end
    end

`ifdef LOT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]   tmr_q [NumL];
    logic [NumL-1:0] err_q;

    always_comb begin
        for (int l = 0; l < NumL; l++) begin
            tmo_hit[l] = (st_q[l] == StOpen) && s1[l] && !s2[l] &&
                         (tmr_q[l] == TW'(TIMEOUT - 1));
        end
    end

    // Counter is held at zero outside OPEN, so it starts cleared on every OPEN entry.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int l = 0; l < NumL; l++) tmr_q[l] <= '0;
            err_q <= '0;
        end else begin
            for (int l = 0; l < NumL; l++) begin
                tmr_q[l] <= (st_q[l] == StOpen) ? tmr_q[l] + 1'b1 : '0;
            end
            err_q <= err_q | tmo_hit;
        end
    end

    assign timeout_err = err_q;
`else
    assign tmo_hit     = '0;
    assign timeout_err = '0;
`endif

    assign in_open   = open_vec[NumIn-1:0];
    assign out_open  = open_vec[NumL-1:NumIn];
    assign in_pulse  = |commit_vec[NumIn-1:0];
    assign out_pulse = |commit_vec[NumL-1:NumIn];
    assign occupancy = occ_q;
    assign full      = (occ_q == CW'(CAPACITY));
    assign empty     = (occ_q == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl: directed test-plan steps plus random sensor traffic,
// all compared each cycle against a behavioural lot model.
module tb_parking_lot_ctrl;

    localparam int CAP  = 10;
    localparam int NIN  = 2;
    localparam int NOUT = 2;
    localparam int TMO  = 15;
    localparam int NL   = NIN + NOUT;
    localparam int CW   = $clog2(CAP + 1);

    logic            clk_2 = 1'b0;
    logic            reset;
    logic [NIN-1:0]  in_a, in_b, in_open, in_wait;
    logic [NOUT-1:0] out_a, out_b, out_open;
    logic [CW-1:0]   occupancy;
    logic            full, empty, in_pulse, out_pulse;
    logic [NL-1:0]   timeout_err;

    parking_lot_ctrl #(
        .CAPACITY (CAP),
        .NIN      (NIN),
        .NOUT     (NOUT),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_a       (out_a),
        .out_b       (out_b),
        .in_open     (in_open),
        .out_open    (out_open),
        .in_wait     (in_wait),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty),
        .in_pulse    (in_pulse),
        .out_pulse   (out_pulse),
        .timeout_err (timeout_err)
    );

    always #5 clk_2 = ~clk_2;

    int errors = 0;
    int checks = 0;

    // Model: per-lane car phase (0 no car, 1 gate up waiting, 2 car in gate, 3 car through),
    // cycles spent waiting with gate up, car count and sticky timeout flags.
    int            m_ph [NL];
    int            m_tm [NL];
    int            m_occ;
    logic [NL-1:0] m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            m_ph[l] = 0;
            m_tm[l] = 0;
        end
        m_occ = 0;
        m_err = '0;
    endtask

    task automatic tick();
        logic [NL-1:0]  s1, s2, grant, opn;
        logic [NIN-1:0] wt;
        int             free, avail, nin, nout;
        @(negedge clk_2);
        s1    = {out_a, in_a};
        s2    = {out_b, in_b};
        free  = CAP - m_occ;
        avail = m_occ;
        for (int l = 0; l < NL; l++) begin
            if (m_ph[l] != 0) begin
                if (l < NIN) free--;
                else avail--;
            end
        end
        grant = '0;
        wt    = '0;
        nin   = 0;
        nout  = 0;
        for (int l = 0; l < NL; l++) begin
            opn[l] = (m_ph[l] == 1 || m_ph[l] == 2);
            if (m_ph[l] == 3) begin
                if (l < NIN) nin++;
                else nout++;
            end
            if (m_ph[l] == 0 && s1[l]) begin
                if (l < NIN) begin
                    if (free > 0) begin grant[l] = 1'b1; free--; end
                    else wt[l] = 1'b1;
                end else if (avail > 0) begin
                    grant[l] = 1'b1;
                    avail--;
                end
            end
        end
        chk("in_open", in_open, opn[NIN-1:0]);
        chk("out_open", out_open, opn[NL-1:NIN]);
        chk("in_wait", in_wait, wt);
        chk("occupancy", occupancy, m_occ);
        chk("full", full, m_occ == CAP);
        chk("empty", empty, m_occ == 0);
        chk("in_pulse", in_pulse, nin > 0);
        chk("out_pulse", out_pulse, nout > 0);
        chk("timeout_err", timeout_err, m_err);
        @(posedge clk_2);
        if (reset) begin
            model_reset();
        end else begin
            m_occ = m_occ + nin - nout;
            for (int l = 0; l < NL; l++) begin
                case (m_ph[l])
                    0: if (grant[l]) begin m_ph[l] = 1; m_tm[l] = 0; end
                    1: begin
                        if (s2[l]) m_ph[l] = 2;
                        else if (!s1[l]) m_ph[l] = 0;
`ifdef LOT_TIMEOUT_EN
                        else begin
                            m_tm[l]++;
                            if (m_tm[l] == TMO) begin m_ph[l] = 0; m_err[l] = 1'b1; end
                        end
`endif
                    end
                    2: if (!s1[l] && !s2[l]) m_ph[l] = 3;
                    default: m_ph[l] = 0;
                endcase
            end
        end
        #1;
    endtask

    task automatic enter(input int l);
        in_a[l] = 1'b1; tick();
        in_b[l] = 1'b1; tick();
        in_a[l] = 1'b0; tick();
        in_b[l] = 1'b0; tick();
        tick();
    endtask

    task automatic leave(input int l);
        out_a[l] = 1'b1; tick();
        out_b[l] = 1'b1; tick();
        out_a[l] = 1'b0; tick();
        out_b[l] = 1'b0; tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        in_a  = '0;
        in_b  = '0;
        out_a = '0;
        out_b = '0;
        repeat (2) @(posedge clk_2);
        #1;
        model_reset();
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_open", {out_open, in_open}, 0);
        reset = 1'b0;
        tick();

        // Fill the lot through lane 0.
        for (int i = 1; i <= CAP; i++) begin
            enter(0);
            chk("fill_occupancy", occupancy, i);
        end
        chk("fill_full", full, 1);
        in_a[0] = 1'b1; tick(); tick();
        chk("full_no_open", in_open[0], 0);
        chk("full_wait", in_wait[0], 1);
        in_a[0] = 1'b0; tick();

        // One slot left, two simultaneous requests.
        leave(0);
        chk("one_free_occ", occupancy, 9);
        in_a = 2'b11; tick();
        chk("prio_open", in_open, 2'b01);
        chk("prio_wait", in_wait, 2'b10);
        in_b[0] = 1'b1; tick();
        in_a[0] = 1'b0; tick();
        in_b[0] = 1'b0; tick();
        tick();
        chk("prio_occ", occupancy, 10);
        chk("prio_still_wait", in_wait[1], 1);
        in_a[1] = 1'b0; tick();

        // Concurrent entry and exit at occupancy 5.
        for (int i = 0; i < 5; i++) leave(i % 2);
        chk("five_occ", occupancy, 5);
        in_a[0] = 1'b1; out_a[1] = 1'b1; tick();
        in_b[0] = 1'b1; out_b[1] = 1'b1; tick();
        in_a[0] = 1'b0; out_a[1] = 1'b0; tick();
        in_b[0] = 1'b0; out_b[1] = 1'b0; tick();
        chk("both_pulse", {in_pulse, out_pulse}, 2'b11);
        tick();
        chk("net_occ", occupancy, 5);

        // Backout frees the reservation without counting.
        in_a[0] = 1'b1; tick();
        chk("backout_open", in_open[0], 1);
        in_a[0] = 1'b0; tick();
        chk("backout_closed", in_open[0], 0);
        tick();
        chk("backout_occ", occupancy, 5);

        // Exit request on an empty lot, then reset mid-transit.
        for (int i = 0; i < 5; i++) leave(0);
        out_a[0] = 1'b1; tick(); tick();
        chk("empty_no_open", out_open[0], 0);
        chk("empty_flag", empty, 1);
        out_a[0] = 1'b0; tick();
        for (int i = 0; i < 3; i++) enter(1);
        in_a[0] = 1'b1; tick();
        in_b[0] = 1'b1; tick();
        chk("pass_open", in_open[0], 1);
        reset = 1'b1; in_a = '0; in_b = '0; tick();
        reset = 1'b0;
        chk("midrst_occ", occupancy, 0);
        chk("midrst_open", {out_open, in_open}, 0);
        tick();

`ifdef LOT_TIMEOUT_EN
        in_a[1] = 1'b1; tick();
        repeat (TMO - 1) tick();
        chk("tmo_still_open", in_open[1], 1);
        tick();
        chk("tmo_closed", in_open[1], 0);
        chk("tmo_err", timeout_err[1], 1);
        tick();
        chk("tmo_rerequest", in_open[1], 1);
        in_a[1] = 1'b0; tick(); tick();
`else
        chk("tmo_tied_off", timeout_err, 0);
`endif

        // Random sensor traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            in_a  = NIN'($urandom_range(0, (1 << NIN) - 1));
            in_b  = NIN'($urandom_range(0, (1 << NIN) - 1));
            out_a = NOUT'($urandom_range(0, (1 << NOUT) - 1));
            out_b = NOUT'($urandom_range(0, (1 << NOUT) - 1));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        in_a  = '0; in_b = '0; out_a = '0; out_b = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
